// File: rtl/zvc_reduce_sched_if.sv
// Handshake bundle for zvc_reduce_sched: input vector (valid/ready),
// output sum (valid/ready) and the busy status flag.
// master = producer/consumer side, slave = the scheduler.
interface zvc_reduce_sched_if #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 8
);
  localparam int SUM_WIDTH = WORD_WIDTH + $clog2(NUM_WORDS);

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_WORDS*WORD_WIDTH-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [SUM_WIDTH-1:0]            out_sum;
  logic                            busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/zvc_reduce_sched.sv
// ZVC reduction scheduler: sums NUM_WORDS words by time-sharing a single
// node_adder across the levels of a binary adder tree (one add per cycle,
// NUM_WORDS-1 cycles per vector).
// Optional build macro ZVC_NZ_COUNT_EN: each word is loaded as 1 when
// nonzero and 0 otherwise, so the result is the nonzero-word count.

// Single two-input adder node; y carries one extra bit for the carry-out.
module node_adder #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH:0]   y
);
  assign y = {1'b0, a} + {1'b0, b};
endmodule

module zvc_reduce_sched #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  zvc_reduce_sched_if.slave bus
);
  localparam int SUM_WIDTH = WORD_WIDTH + $clog2(NUM_WORDS);
  localparam int PW        = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam int AW        = PW + 1;

  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_num_words
    $error("zvc_reduce_sched: NUM_WORDS must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [SUM_WIDTH-1:0] slot [NUM_WORDS];
  logic [PW-1:0]        pair_idx;
  logic [AW-1:0]        active_cnt;
  logic [SUM_WIDTH-1:0] out_sum_q;

  logic [PW-1:0]        idx_a;
  logic [PW-1:0]        idx_b;
  logic [SUM_WIDTH:0]   add_y;
  logic [SUM_WIDTH-1:0] add_sum;
  logic                 carry_unused;
  logic                 last_of_level;
  logic                 final_pair;
  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 busy_c;

  // Operand pair for this cycle: slots 2*pair_idx and 2*pair_idx+1.
  // Writing back to slot[pair_idx] is safe because pair_idx never exceeds
  // any index still to be read within the current level.
  assign idx_a = pair_idx << 1;
  assign idx_b = idx_a | PW'(1);

  node_adder #(.WORD_WIDTH(SUM_WIDTH)) u_node_adder (
    .a (slot[idx_a]),
    .b (slot[idx_b]),
    .y (add_y)
  );

  // Slots are SUM_WIDTH wide, enough for the full tree total, so the
  // carry-out can never be set.
  assign add_sum      = add_y[SUM_WIDTH-1:0];
  assign carry_unused = add_y[SUM_WIDTH];

  assign last_of_level = (AW'(pair_idx) + AW'(1)) == (active_cnt >> 1);
  assign final_pair    = (active_cnt == AW'(2));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs, decoded from the current state only.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (final_pair) state_d = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot storage, tree walk counters and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the slot array is cleared on reset on purpose; it is small
      // register storage, and a defined post-reset image is part of the
      // block's reset state rather than something left to chance.
      for (int k = 0; k < NUM_WORDS; k++) slot[k] <= '0;
      pair_idx   <= '0;
      active_cnt <= AW'(NUM_WORDS);
      out_sum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
`ifdef ZVC_NZ_COUNT_EN
              slot[k] <= (bus.in_data[k*WORD_WIDTH +: WORD_WIDTH] != '0)
                         ? SUM_WIDTH'(1) : '0;
`else
              slot[k] <= SUM_WIDTH'(bus.in_data[k*WORD_WIDTH +: WORD_WIDTH]);
`endif
            end
            active_cnt <= AW'(NUM_WORDS);
            pair_idx   <= '0;
          end
        end
        RUN: begin
          slot[pair_idx] <= add_sum;
          if (last_of_level) begin
            active_cnt <= active_cnt >> 1;
            pair_idx   <= '0;
          end else begin
            pair_idx <= pair_idx + PW'(1);
          end
          if (final_pair) out_sum_q <= add_sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_zvc_reduce_sched.sv
// Directed self-checking bench for zvc_reduce_sched (WORD_WIDTH=4,
// NUM_WORDS=8, SUM_WIDTH=7). Expected results are hand-computed for both
// builds (ZVC_NZ_COUNT_EN defined or not).
module tb_zvc_reduce_sched;
  localparam int WW = 4;
  localparam int NW = 8;
  localparam int SW = 7;

  // word0 is the lowest nibble of each vector
  localparam logic [31:0] V_SEQ    = 32'h8765_4321; // 1..8
  localparam logic [31:0] V_MAX    = 32'hFFFF_FFFF; // all 15
  localparam logic [31:0] V_TWOS   = 32'h2222_2222; // all 2
  localparam logic [31:0] V_SPARSE = 32'h001F_0050; // {0,5,0,0,15,1,0,0}
  localparam logic [31:0] V_ZERO   = 32'h0000_0000;
  localparam logic [31:0] V_B1     = 32'h6429_1703; // {3,0,7,1,9,2,4,6}
  localparam logic [31:0] V_B2     = 32'h89AB_CDEF; // {15,14,...,8}

`ifdef ZVC_NZ_COUNT_EN
  localparam int E_SEQ = 8, E_MAX = 8, E_TWOS = 8, E_SPARSE = 3, E_B1 = 7, E_B2 = 8;
`else
  localparam int E_SEQ = 36, E_MAX = 120, E_TWOS = 16, E_SPARSE = 21, E_B1 = 32, E_B2 = 92;
`endif
  localparam int E_ZERO = 0;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   check_cnt;

  zvc_reduce_sched_if #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) bus ();

  zvc_reduce_sched #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Present a vector at a negedge, let the next posedge accept it, and
  // return at the following negedge with in_valid dropped.
  task automatic send(input logic [31:0] d);
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int n, output bit rdy_low);
    n       = 0;
    rdy_low = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_sum !== SW'(0))
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_sum=%0d expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sum_latency;
    int n;
    bit rdy_low;
    bus.out_ready = 1'b1;
    send(V_SEQ);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7) $display("FAIL seq_latency: out_valid after %0d cycles, expected 7", n);
    else pass_cnt++;
    check_cnt++;
    if (!rdy_low) $display("FAIL seq_in_ready: in_ready seen high during RUN, expected 0");
    else pass_cnt++;
    check_cnt++;
    if (bus.out_sum !== SW'(E_SEQ)) $display("FAIL seq_sum: out_sum=%0d expected %0d", bus.out_sum, E_SEQ);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL seq_one_cycle: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_max_value;
    int n;
    bit rdy_low;
    send(V_MAX);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7 || bus.out_sum !== SW'(E_MAX))
      $display("FAIL max_sum: latency=%0d out_sum=%0d expected 7 %0d", n, bus.out_sum, E_MAX);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n;
    bit rdy_low;
    bus.out_ready = 1'b0;
    send(V_SEQ);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7) $display("FAIL bp_latency: out_valid after %0d cycles, expected 7", n);
    else pass_cnt++;
    bus.in_data  = V_TWOS;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== SW'(E_SEQ) || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: out_valid=%b out_sum=%0d in_ready=%b expected 1 %0d 0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready, E_SEQ);
      else pass_cnt++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_sum !== SW'(E_SEQ))
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b out_sum=%0d expected 0 1 0 %0d",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, E_SEQ);
    else pass_cnt++;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) n++;
    end
    check_cnt++;
    if (n !== 0) $display("FAIL bp_ignored_input: %0d cycles busy/valid after release, expected 0", n);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int n;
    bit rdy_low;
    send(V_SEQ);
    repeat (2) @(negedge clk);
    check_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL rst_pre_busy: busy=%b expected 1", bus.busy);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL rst_async: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (bus.out_sum !== SW'(0)) $display("FAIL rst_out_sum: out_sum=%0d expected 0", bus.out_sum);
    else pass_cnt++;
    reset = 1'b0;
    send(V_TWOS);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7 || bus.out_sum !== SW'(E_TWOS))
      $display("FAIL rst_recover: latency=%0d out_sum=%0d expected 7 %0d", n, bus.out_sum, E_TWOS);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_nz_count;
    int n;
    bit rdy_low;
    send(V_SPARSE);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7 || bus.out_sum !== SW'(E_SPARSE))
      $display("FAIL sparse_sum: latency=%0d out_sum=%0d expected 7 %0d", n, bus.out_sum, E_SPARSE);
    else pass_cnt++;
    @(negedge clk);
    send(V_ZERO);
    wait_done(n, rdy_low);
    check_cnt++;
    if (n !== 7 || bus.out_sum !== SW'(E_ZERO))
      $display("FAIL zero_sum: latency=%0d out_sum=%0d expected 7 %0d", n, bus.out_sum, E_ZERO);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] vec [3];
    int          exp_sum [3];
    int          acc_cyc [3];
    int          n_acc, n_res, cyc, extra;
    bit          will_acc;
    vec[0] = V_SEQ; vec[1] = V_B1; vec[2] = V_B2;
    exp_sum[0] = E_SEQ; exp_sum[1] = E_B1; exp_sum[2] = E_B2;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    n_acc = 0; n_res = 0; cyc = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_data   = vec[0];
    bus.in_valid  = 1'b1;
    while ((n_acc < 3 || n_res < 3) && cyc < 100) begin
      will_acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (will_acc && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) bus.in_data = vec[n_acc];
        else           bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        check_cnt++;
        if (n_res >= 3 || bus.out_sum !== SW'(exp_sum[n_res]))
          $display("FAIL b2b_sum[%0d]: out_sum=%0d expected %0d", n_res, bus.out_sum,
                   (n_res < 3) ? exp_sum[n_res] : -1);
        else pass_cnt++;
        n_res++;
      end
    end
    check_cnt++;
    if (n_acc !== 3 || n_res !== 3)
      $display("FAIL b2b_count: accepted=%0d results=%0d expected 3 3", n_acc, n_res);
    else pass_cnt++;
    check_cnt++;
    if (acc_cyc[1] - acc_cyc[0] !== 9 || acc_cyc[2] - acc_cyc[1] !== 9)
      $display("FAIL b2b_spacing: gaps=%0d,%0d expected 9,9",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    check_cnt++;
    if (extra !== 0) $display("FAIL b2b_duplicate: %0d extra out_valid cycles, expected 0", extra);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    test_reset();
    test_sum_latency();
    test_max_value();
    test_backpressure();
    test_reset_mid_run();
    test_nz_count();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
